// File: rtl/poly_arith_pkg.sv
// Shared types and constants for ML-KEM polynomial arithmetic over Z_q, q = 3329.
package poly_arith_pkg;

  localparam int COEF_W = 12;

  typedef logic [COEF_W-1:0] coeff_t;

  localparam coeff_t Q          = 12'd3329;
  // 2^-1 mod q; the halving path uses the (t+q)>>1 form instead of a multiply
  localparam coeff_t Q_HALF_INV = 12'd1665;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    BFLY = 2'b10,
    HADD = 2'b11
  } mode_t;

endpackage

// File: rtl/mod_add_sub_pipe_if.sv
// Beat-level valid/ready bus for the modular add/sub pipeline, named from the block's point of view.
interface mod_add_sub_pipe_if
  import poly_arith_pkg::*;
#(
  parameter int LANES = 4
);

  logic                    valid_i;
  logic                    ready_o;
  mode_t                   mode_i;
  logic [LANES*COEF_W-1:0] op1_i;
  logic [LANES*COEF_W-1:0] op2_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [LANES*COEF_W-1:0] sum_o;
  logic [LANES*COEF_W-1:0] diff_o;

  modport slave (
    input  valid_i, mode_i, op1_i, op2_i, ready_i,
    output ready_o, valid_o, sum_o, diff_o
  );

  modport master (
    output valid_i, mode_i, op1_i, op2_i, ready_i,
    input  ready_o, valid_o, sum_o, diff_o
  );

endinterface

// File: rtl/mod_add_sub_pipe_lane.sv
// One combinational lane: modular add, sub, butterfly and halved-add over Z_q.
module mod_add_sub_lane
  import poly_arith_pkg::*;
(
  input  coeff_t a,
  input  coeff_t b,
  input  mode_t  mode,
  output coeff_t sum,
  output coeff_t diff
);

  coeff_t add_r;
  coeff_t sub_r;

  // Single conditional subtraction; enough because both 13-bit inputs stay below 2q.
  function automatic coeff_t cond_sub_q(input logic [COEF_W:0] x);
    return COEF_W'((x >= {1'b0, Q}) ? (x - {1'b0, Q}) : x);
  endfunction

  // Multiply by 2^-1 mod q: odd values are made even by adding q before the shift.
  function automatic coeff_t halve_mod_q(input coeff_t t);
    logic [COEF_W:0] x;
    x = t[0] ? ({1'b0, t} + {1'b0, Q}) : {1'b0, t};
    return COEF_W'(x >> 1);
  endfunction

  always_comb begin
    add_r = cond_sub_q({1'b0, a} + {1'b0, b});
    sub_r = cond_sub_q({1'b0, a} + {1'b0, Q} - {1'b0, b});
    sum   = add_r;
    diff  = '0;
    case (mode)
      SUB:     sum  = sub_r;
      BFLY:    diff = sub_r;
      HADD:    sum  = halve_mod_q(add_r);
      default: ;
    endcase
  end

endmodule

// File: rtl/mod_add_sub_pipe.sv
// Multi-lane pipelined modular adder/subtractor with a globally stalled valid/ready pipeline.
module mod_add_sub_pipe
  import poly_arith_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int STAGES = 2
)(
  input  logic               clk_i,
  input  logic               rst_i,
  mod_add_sub_pipe_if.slave  bus
);

  localparam int W = LANES * COEF_W;

  logic [W-1:0] lane_sum;
  logic [W-1:0] lane_diff;
  logic         adv;

  logic         vld_p_q  [1:STAGES];
  logic         vld_p_d  [1:STAGES];
  logic [W-1:0] sum_p_q  [1:STAGES];
  logic [W-1:0] sum_p_d  [1:STAGES];
  logic [W-1:0] diff_p_q [1:STAGES];
  logic [W-1:0] diff_p_d [1:STAGES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod_add_sub_lane u_lane (
      .a    (bus.op1_i[COEF_W*k +: COEF_W]),
      .b    (bus.op2_i[COEF_W*k +: COEF_W]),
      .mode (bus.mode_i),
      .sum  (lane_sum[COEF_W*k +: COEF_W]),
      .diff (lane_diff[COEF_W*k +: COEF_W])
    );
  end

  always_comb begin
    adv = bus.ready_i || !vld_p_q[STAGES];
    for (int s = 1; s <= STAGES; s++) begin
      vld_p_d[s]  = vld_p_q[s];
      sum_p_d[s]  = sum_p_q[s];
      diff_p_d[s] = diff_p_q[s];
    end
    if (adv) begin
      // p1: lane results; p2..pSTAGES: pure delay, free for retiming
      vld_p_d[1]  = bus.valid_i;
      sum_p_d[1]  = lane_sum;
      diff_p_d[1] = lane_diff;
      for (int s = 2; s <= STAGES; s++) begin
        vld_p_d[s]  = vld_p_q[s-1];
        sum_p_d[s]  = sum_p_q[s-1];
        diff_p_d[s] = diff_p_q[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 1; s <= STAGES; s++) begin
      if (rst_i) begin
        vld_p_q[s] <= 1'b0;
      end else begin
        vld_p_q[s] <= vld_p_d[s];
      end
      sum_p_q[s]  <= sum_p_d[s];
      diff_p_q[s] <= diff_p_d[s];
    end
  end

  // Data registers carry no reset, so outputs are gated to read zero without a valid beat.
  assign bus.ready_o = adv;
  assign bus.valid_o = vld_p_q[STAGES];
  assign bus.sum_o   = vld_p_q[STAGES] ? sum_p_q[STAGES]  : '0;
  assign bus.diff_o  = vld_p_q[STAGES] ? diff_p_q[STAGES] : '0;

endmodule

// File: tb/tb_mod_add_sub_pipe.sv
// Directed and scoreboard-checked stimulus for mod_add_sub_pipe (LANES=4, STAGES=2).
module tb_mod_add_sub_pipe;
  import poly_arith_pkg::*;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int W      = LANES * 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_add_sub_pipe_if #(.LANES(LANES)) bus ();

  mod_add_sub_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;
  int   accepted  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  function automatic exp_t model(input mode_t m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int x, y, ad, sd, h;
    e.s = '0;
    e.d = '0;
    for (int k = 0; k < LANES; k++) begin
      x  = int'(a[12*k +: 12]);
      y  = int'(b[12*k +: 12]);
      ad = (x + y) % 3329;
      sd = (x - y + 3329) % 3329;
      h  = (ad % 2 == 0) ? ad / 2 : (ad + 3329) / 2;
      case (m)
        ADD:  e.s[12*k +: 12] = 12'(ad);
        SUB:  e.s[12*k +: 12] = 12'(sd);
        BFLY: begin e.s[12*k +: 12] = 12'(ad); e.d[12*k +: 12] = 12'(sd); end
        default: e.s[12*k +: 12] = 12'(h);
      endcase
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mode_t m, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < LANES; k++) begin
      assert (a[12*k +: 12] < 12'd3329 && b[12*k +: 12] < 12'd3329)
        else $error("FAIL illegal_input: lane %0d a=%0d b=%0d", k, a[12*k +: 12], b[12*k +: 12]);
    end
    bus.valid_i = 1'b1;
    bus.mode_i  = m;
    bus.op1_i   = a;
    bus.op2_i   = b;
  endtask

  function automatic logic [W-1:0] rnd_vec();
    return pk($urandom_range(0, 3328), $urandom_range(0, 3328),
              $urandom_range(0, 3328), $urandom_range(0, 3328));
  endfunction

  // One beat with ready_i high, then checks latency, result and that it is not repeated.
  task automatic single(input string tag, input mode_t m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] es, input logic [W-1:0] ed);
    bus.ready_i = 1'b1;
    drive(m, a, b);
    step();
    bus.valid_i = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      check({tag, "_early_vld"}, W'(bus.valid_o), W'(1'b0));
      step();
    end
    check({tag, "_vld"},  W'(bus.valid_o), W'(1'b1));
    check({tag, "_sum"},  bus.sum_o, es);
    check({tag, "_diff"}, bus.diff_o, ed);
    step();
    check({tag, "_no_dup"}, W'(bus.valid_o), W'(1'b0));
  endtask

  // One clock of scoreboard traffic with inputs already driven.
  task automatic cycle(output logic acc);
    exp_t         e;
    logic         stalled;
    logic [W-1:0] hs, hd;
    #1;
    stalled = bus.valid_o && !bus.ready_i;
    hs = bus.sum_o;
    hd = bus.diff_o;
    if (stalled) check("stall_ready_o", W'(bus.ready_o), W'(1'b0));
    if (bus.valid_o && bus.ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_beat", W'(bus.valid_o), W'(1'b0));
      end else begin
        e = sb.pop_front();
        check("sb_sum",  bus.sum_o,  e.s);
        check("sb_diff", bus.diff_o, e.d);
        delivered++;
      end
    end
    acc = bus.valid_i && bus.ready_o;
    if (acc) sb.push_back(model(bus.mode_i, bus.op1_i, bus.op2_i));
    step();
    if (stalled) begin
      check("hold_vld",  W'(bus.valid_o), W'(1'b1));
      check("hold_sum",  bus.sum_o,  hs);
      check("hold_diff", bus.diff_o, hd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   nb;
    int   budget;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.mode_i  = ADD;
    bus.op1_i   = '0;
    bus.op2_i   = '0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_vld",  W'(bus.valid_o), W'(1'b0));
    check("rst_sum",  bus.sum_o, '0);
    check("rst_diff", bus.diff_o, '0);
    rst = 1'b0;
    step();
    check("post_rst_vld", W'(bus.valid_o), W'(1'b0));

    single("add",  ADD,  pk(3328, 3328, 0, 1000), pk(1, 3328, 0, 2329),
           pk(0, 3327, 0, 0), pk(0, 0, 0, 0));
    single("sub",  SUB,  pk(0, 500, 5, 3), pk(1, 500, 3, 5),
           pk(3328, 0, 2, 3327), pk(0, 0, 0, 0));
    single("bfly", BFLY, pk(10, 3328, 0, 1), pk(20, 1, 0, 3328),
           pk(30, 0, 0, 0), pk(3319, 3327, 0, 2));
    single("hadd", HADD, pk(1, 3328, 2, 0), pk(0, 3328, 2, 0),
           pk(1665, 3328, 2, 0), pk(0, 0, 0, 0));

    // Backpressure: 8 beats, ready_i low during cycles 3..5.
    delivered = 0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      if (nb < 8) drive(ADD, pk(nb + 1, 100, 0, 0), pk(100, nb, 0, 0));
      else        bus.valid_i = 1'b0;
      bus.ready_i = !(c >= 3 && c <= 5);
      cycle(acc);
      if (acc) nb++;
    end
    check("bp_delivered", W'(delivered), W'(8));
    check("bp_sb_empty",  W'(sb.size()), W'(0));

    // Reset with STAGES beats in flight.
    bus.ready_i = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      drive(BFLY, rnd_vec(), rnd_vec());
      step();
    end
    bus.valid_i = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_vld",  W'(bus.valid_o), W'(1'b0));
    check("midrst_sum",  bus.sum_o, '0);
    check("midrst_diff", bus.diff_o, '0);
    rst = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      step();
      check("midrst_quiet", W'(bus.valid_o), W'(1'b0));
    end

    // Random traffic against the golden model.
    sb.delete();
    delivered = 0;
    accepted  = 0;
    budget    = 0;
    while (accepted < 1000 && budget < 10000) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.mode_i  = mode_t'($urandom_range(0, 3));
      bus.op1_i   = rnd_vec();
      bus.op2_i   = rnd_vec();
      bus.ready_i = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) accepted++;
      budget++;
    end
    check("rnd_accepted", W'(accepted), W'(1000));
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < STAGES + 3; i++) cycle(acc);
    check("rnd_delivered", W'(delivered), W'(accepted));
    check("rnd_sb_empty",  W'(sb.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
